// File: rtl/msg_stream_ctrl.sv
// rtl/msg_stream_ctrl.sv - ROM message sequencer with valid/ready byte output, looping and abort
//
// Purpose:
//   Plays one of two stored messages out of a synchronous character ROM one
//   byte at a time. The message selection and the inter-byte gap are latched
//   when playback starts. rom_addr is walked alongside char_idx. Each byte is
//   presented on out_data/out_valid until the consumer takes it.
//
// Ports:
//   clk        in   1  clock, all logic on posedge
//   rst_n      in   1  synchronous reset, active HIGH (despite the name)
//   start      in   1  begin playback when idle (level sampled)
//   abort      in   1  return to idle, drop out_valid, no done pulse
//   msg_sel    in   2  00/11 -> message 0, 01/10 -> message 1
//   loop       in   1  replay from byte 0 after the last byte
//   div        in   8  idle gap cycles between bytes
//   rom_addr   out  8  registered ROM read address
//   rom_data   in   8  ROM data, valid one cycle after rom_addr
//   out_data   out  8  current byte
//   out_valid  out  1  out_data valid
//   out_ready  in   1  consumer accepts the byte
//   busy       out  1  not idle
//   done       out  1  one-cycle pulse after the final byte of a non-looping pass
//   char_idx   out  7  index of the byte being fetched or presented

module msg_stream_ctrl #(
    parameter logic [7:0] MSG0_BASE = 8'd0,
    parameter logic [6:0] MSG0_LEN  = 7'd126,
    parameter logic [7:0] MSG1_BASE = 8'd128,
    parameter logic [6:0] MSG1_LEN  = 7'd77
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] msg_sel,
    input  logic       loop,
    input  logic [7:0] div,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [6:0] char_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       done_q,  done_d;
    logic [6:0] idx_q,   idx_d;
    logic [7:0] gap_q,   gap_d;
    logic [7:0] base_q,  base_d;
    logic [6:0] len_q,   len_d;
    logic [7:0] div_q,   div_d;

    logic sel_msg1;
    logic xfer;
    logic last_byte;

    // 01 and 10 select message 1; 00 and 11 select message 0.
    assign sel_msg1  = msg_sel[0] ^ msg_sel[1];
    assign xfer      = valid_q && out_ready;
    assign last_byte = (idx_q == (len_q - 7'd1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 7'd0;
            gap_q   <= 8'd0;
            base_q  <= 8'd0;
            len_q   <= 7'd0;
            div_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            base_q  <= base_d;
            len_q   <= len_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        gap_d   = gap_q;
        base_d  = base_q;
        len_d   = len_q;
        div_d   = div_q;

        case (state_q)
            S_IDLE: begin
                // abort beats start, so nothing is latched when both are high
                if (start && !abort) begin
                    base_d  = sel_msg1 ? MSG1_BASE : MSG0_BASE;
                    len_d   = sel_msg1 ? MSG1_LEN  : MSG0_LEN;
                    addr_d  = sel_msg1 ? MSG1_BASE : MSG0_BASE;
                    div_d   = div;
                    idx_d   = 7'd0;
                    state_d = S_FETCH;
                end
            end

            // rom_addr is already stable; the ROM registers it on this edge
            S_FETCH: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                data_d  = rom_data;
                valid_d = 1'b1;
                state_d = S_PRESENT;
            end

            S_PRESENT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (last_byte && !loop) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (last_byte) begin
                            idx_d  = 7'd0;
                            addr_d = base_q;
                        end else begin
                            idx_d  = idx_q + 7'd1;
                            addr_d = addr_q + 8'd1;   // wraps mod 256 by width
                        end
                        // the loop wrap uses the same gap as any other byte
                        if (div_q == 8'd0) begin
                            state_d = S_FETCH;
                        end else begin
                            gap_d   = div_q;
                            state_d = S_GAP;
                        end
                    end
                end
            end

            // gap_q is loaded with div and counts down, one GAP cycle per count
            S_GAP: begin
                if (gap_q <= 8'd1) begin
                    gap_d   = 8'd0;
                    state_d = S_FETCH;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A transfer on the same edge still advances idx/addr. The byte was
        // taken, but the pass ends without a done pulse.
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            data_d  = data_q;
        end
    end

    assign rom_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign char_idx  = idx_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_msg_stream_ctrl.sv
// tb/tb_msg_stream_ctrl.sv - directed table and sequence bench for msg_stream_ctrl

module tb_msg_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, loop, out_ready;
    logic [1:0] msg_sel;
    logic [7:0] div, rom_addr, rom_data, out_data;
    logic       out_valid, busy, done;
    logic [6:0] char_idx;

    logic [7:0] rom [256];

    int n_cmp  = 0;
    int n_fail = 0;

    msg_stream_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .msg_sel   (msg_sel),
        .loop      (loop),
        .div       (div),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .char_idx  (char_idx)
    );

    // synchronous ROM, one-cycle read latency
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic       st;
        logic       ab;
        logic       rdy;
        logic       v;
        logic       b;
        logic       d;
        logic [6:0] idx;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [14];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Plays one full non-looping message and checks order, count, latency,
    // gap length, backpressure stability and the done pulse.
    task automatic run_msg(input string tag, input logic [1:0] sel, input logic [7:0] dv,
                           input bit toggle_rdy, input bit disturb, input int exp_len,
                           input logic [7:0] exp_base, input logic [7:0] exp_first,
                           input logic [7:0] exp_last);
        int got, first_v, low_run, min_low, max_low, order_err, stab_err;
        bit fin, prev_v, prev_x;
        logic [7:0] prev_d, first_b, last_b, ofs;
        got = 0; first_v = -1; low_run = 0; min_low = 1000; max_low = 0;
        order_err = 0; stab_err = 0; fin = 0; prev_v = 0; prev_x = 0;
        prev_d = 8'd0; first_b = 8'd0; last_b = 8'd0;
        msg_sel = sel; div = dv; loop = 1'b0; abort = 1'b0; out_ready = 1'b1; start = 1'b1;
        for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            tick();
            start = 1'b0;
            if (cyc == 1) begin
                chk({tag, " start idx"}, char_idx, 0);
                chk({tag, " start addr"}, rom_addr, exp_base);
            end
            if (disturb && cyc == 40) begin
                start   = 1'b1;
                msg_sel = sel ^ 2'b01;
                div     = dv + 8'd5;
            end
            if (done) begin
                fin = 1;
                chk({tag, " busy at done"}, busy, 0);
            end else begin
                if (out_valid && first_v < 0) first_v = cyc;
                if (prev_v && !prev_x && out_valid && out_data !== prev_d) stab_err++;
                if (!out_valid) begin
                    if (got > 0) low_run++;
                end else if (low_run > 0) begin
                    if (low_run < min_low) min_low = low_run;
                    if (low_run > max_low) max_low = low_run;
                    low_run = 0;
                end
                out_ready = toggle_rdy ? (cyc % 3 == 0) : 1'b1;
                prev_x = out_valid && out_ready;
                if (prev_x) begin
                    ofs = got[7:0];
                    if (out_data !== rom[exp_base + ofs]) order_err++;
                    if (got == 0) first_b = out_data;
                    last_b = out_data;
                    got++;
                end
                prev_v = out_valid;
                prev_d = out_data;
            end
        end
        start = 1'b0;
        chk({tag, " done seen"}, fin, 1);
        chk({tag, " byte count"}, got, exp_len);
        chk({tag, " order errors"}, order_err, 0);
        chk({tag, " stability errors"}, stab_err, 0);
        chk({tag, " first valid cycle"}, first_v, 3);
        chk({tag, " min idle run"}, min_low, dv + 2);
        chk({tag, " max idle run"}, max_low, dv + 2);
        chk({tag, " first byte"}, first_b, exp_first);
        chk({tag, " last byte"}, last_b, exp_last);
        tick();
        chk({tag, " done one cycle"}, done, 0);
        out_ready = 1'b1;
    endtask

    int   lp_got, lp_err;
    bit   lp_fin, lp_wrap, hit;
    logic [7:0] lp_ofs;
    int   lp_tmp;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = i[7:0] * 8'd37 + 8'd11;
        rom[0]   = 8'hA1;
        rom[1]   = 8'h47;
        rom[2]   = 8'h75;
        rom[125] = 8'h0A;
        rom[128] = 8'h50;
        rom[129] = 8'h50;
        rom[204] = 8'h64;

        //             st    ab    rdy   v     b     d     idx    addr   data
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 8'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 8'd0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 8'd0, 8'hA1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 8'd1, 8'hA1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 8'd1, 8'hA1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 8'd1, 8'h47};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 8'd1, 8'h47};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 8'd1, 8'h47};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'd2, 8'h47};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 8'd2, 8'h47};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 8'd2, 8'h75};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 8'd2, 8'h75};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 8'd2, 8'h75};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2, 8'd2, 8'h75};

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
        msg_sel = 2'b00; div = 8'd0; out_ready = 1'b1;
        tick();
        tick();
        chk("reset rom_addr", rom_addr, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset char_idx", char_idx, 0);
        rst_n = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st; abort = tbl[i].ab; out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].v);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d done", i), done, tbl[i].d);
            chk($sformatf("vec%0d char_idx", i), char_idx, tbl[i].idx);
            chk($sformatf("vec%0d rom_addr", i), rom_addr, tbl[i].addr);
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].data);
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        tick();

        run_msg("msg0 div0", 2'b00, 8'd0, 1'b0, 1'b0, 126, 8'd0, 8'hA1, 8'h0A);
        run_msg("msg1 div4 bp", 2'b10, 8'd4, 1'b1, 1'b0, 77, 8'd128, 8'h50, 8'h64);
        run_msg("msg0 disturbed", 2'b11, 8'd2, 1'b1, 1'b1, 126, 8'd0, 8'hA1, 8'h0A);

        // looping: wrap after byte 76, drop loop during the second pass
        msg_sel = 2'b01; div = 8'd0; loop = 1'b1; out_ready = 1'b1; start = 1'b1;
        lp_got = 0; lp_err = 0; lp_fin = 0; lp_wrap = 0;
        for (int c = 0; c < 2000 && !lp_fin; c++) begin
            tick();
            start = 1'b0;
            if (lp_wrap) begin
                chk("loop wrap char_idx", char_idx, 0);
                chk("loop wrap rom_addr", rom_addr, 128);
                chk("loop wrap done", done, 0);
                lp_wrap = 0;
            end
            if (done) begin
                lp_fin = 1;
            end else if (out_valid) begin
                lp_tmp = lp_got % 77;
                lp_ofs = lp_tmp[7:0];
                if (out_data !== rom[8'd128 + lp_ofs]) lp_err++;
                if (lp_got == 76) lp_wrap = 1;
                lp_got++;
                if (lp_got == 100) loop = 1'b0;
            end
        end
        chk("loop done seen", lp_fin, 1);
        chk("loop byte count", lp_got, 154);
        chk("loop order errors", lp_err, 0);
        chk("loop busy at done", busy, 0);
        // start in the done cycle is accepted
        msg_sel = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in done cycle busy", busy, 1);
        chk("start in done cycle addr", rom_addr, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort from fetch busy", busy, 0);
        tick();

        // abort in PRESENT under backpressure at char_idx 10
        msg_sel = 2'b00; div = 8'd2; out_ready = 1'b1; start = 1'b1; hit = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            start = 1'b0;
            if (out_valid && char_idx == 7'd10) begin
                out_ready = 1'b0;
                hit = 1;
                break;
            end
        end
        chk("abort reached idx10", hit, 1);
        tick();
        chk("abort hold valid", out_valid, 1);
        chk("abort hold data", out_data, rom[10]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort out_valid", out_valid, 0);
        chk("abort done", done, 0);
        chk("abort keeps data", out_data, rom[10]);
        tick();
        chk("abort no late done", done, 0);
        out_ready = 1'b1;
        run_msg("replay after abort", 2'b00, 8'd0, 1'b0, 1'b0, 126, 8'd0, 8'hA1, 8'h0A);

        // reset in the middle of a gap
        msg_sel = 2'b01; div = 8'd8; out_ready = 1'b1; start = 1'b1; hit = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            start = 1'b0;
            if (out_valid && char_idx == 7'd3) begin
                hit = 1;
                break;
            end
        end
        chk("gap reached idx3", hit, 1);
        tick();
        chk("in gap busy", busy, 1);
        chk("in gap valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("gap reset rom_addr", rom_addr, 0);
        chk("gap reset out_data", out_data, 0);
        chk("gap reset out_valid", out_valid, 0);
        chk("gap reset busy", busy, 0);
        chk("gap reset done", done, 0);
        chk("gap reset char_idx", char_idx, 0);
        run_msg("msg1 after reset", 2'b01, 8'd1, 1'b1, 1'b0, 77, 8'd128, 8'h50, 8'h64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
